draw_cmd_queue: RTL
===================

Name: draw_cmd_queue

Overview:
- Upstream command stage for the sprite drawer (the block that reads a sprite ROM and writes pixels to the LT24 display).
- Game/application logic pushes draw commands (x, y, sprite id) into a small FIFO.
- The issue FSM hands commands to the drawer one at a time using its draw/ready handshake, and holds the origin stable for the whole draw.
- Sits between the application logic and the sprite drawer; only this block drives the drawer's xOrigin/yOrigin/mifId/draw.

Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥2)
- LCD_WIDTH, 240, x range limit; commands with x ≥ LCD_WIDTH are rejected
- LCD_HEIGHT, 320, y range limit; commands with y ≥ LCD_HEIGHT are rejected
- TIMEOUT_CYCLES, 4000000, watchdog limit (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmdValid  in  1  push request, one command per cycle
- cmdX  in  8  sprite x origin
- cmdY  in  9  sprite y origin
- cmdMif  in  8  sprite/ROM id
- cmdReady  out  1  high when FIFO not full
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: push dropped because FIFO full
- rangeErr  out  1  sticky: push dropped because out of range
- xOrigin  out  8  to drawer
- yOrigin  out  9  to drawer
- mifId  out  8  to drawer
- draw  out  1  to drawer
- drawReady  in  1  drawer ready
- busy  out  1  command in flight (FSM not IDLE)
- doneStrobe  out  1  one-cycle pulse when a draw completes
- timeout  out  1  sticky watchdog flag; tied 0 without the optional feature

Behaviour:
- Reset, asynchronous: FIFO emptied, count=0, cmdReady=1, overflow=0, rangeErr=0, draw=0, xOrigin/yOrigin/mifId=0, busy=0, doneStrobe=0, timeout=0, FSM=S_IDLE.
- Reset asserted mid-draw: draw drops immediately and the queued commands are lost. The drawer shares the reset, so both restart together.

FIFO:
- Registered pointers; head entry is readable from registers.
- Push is accepted when cmdValid=1, cmdX<LCD_WIDTH, cmdY<LCD_HEIGHT, and (not full, or a pop occurs in the same cycle).
- Full with no pop: push dropped, overflow set.
- Out of range: push dropped, rangeErr set; overflow unaffected.
- Pushed entry is poppable from the next cycle (count updates at the edge).
- Simultaneous push and pop: count unchanged.
- Pointers wrap modulo DEPTH.

Issue FSM:
- S_IDLE:
  - if count>0 and drawReady=1: latch head into xOrigin/yOrigin/mifId, pop, go to S_ASSERT.
- S_ASSERT: draw=1.
  - When drawReady=0 (drawer accepted): draw=0, go to S_WAIT_DONE.
- S_WAIT_DONE: draw=0.
  - When drawReady=1: doneStrobe=1 for one cycle, go to S_IDLE.
- xOrigin/yOrigin/mifId stay constant from S_ASSERT entry until S_IDLE is re-entered, because the drawer compares its address against the origin throughout the draw.
- All drawer outputs are registered.
- busy=1 in S_ASSERT and S_WAIT_DONE.
- Latency: a command pushed into an empty queue with drawReady=1 gives draw=1 three cycles after the push edge (push edge, load edge, draw edge).
- Back-to-back commands: the next load waits for S_IDLE and drawReady=1. No command is issued while busy.

Optional Feature:
- DRAW_CMD_QUEUE_WATCHDOG_EN defined:
  - A 22-bit counter runs in S_ASSERT and S_WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: draw=0, timeout set (sticky), return to S_IDLE, no doneStrobe.
  - Counter clears on every state change.
- Undefined: no counter; timeout tied 0; the FSM can wait indefinitely.

Decomposition:
- Shared display package:
  - LCD_WIDTH/LCD_HEIGHT constants
  - draw command struct {x[7:0], y[8:0], mif[7:0]}, 25 bits
  - FSM state encoding constants
- One natural sub-module: sync_fifo, parameterised on width and depth, with full/empty/count. The issue FSM stays in the top module.

Test Plan:
- Single command: push (x=10, y=20, mif=1); drawer model drops ready 2 cycles after draw and raises it 100 cycles later. Expect draw for exactly the cycles until ready falls, xOrigin=10/yOrigin=20 held throughout, one doneStrobe, count back to 0.
- Fill: push 9 commands back-to-back with drawReady=0 and DEPTH=8. Expect cmdReady=0 after the 8th, 9th dropped, overflow=1, count=8; then 8 draws complete in push order.
- Push while full with a pop in the same cycle: expect the push accepted, count stays 8, overflow stays 0.
- Range: push x=240, then y=320. Expect both dropped, rangeErr=1, count=0, no draw.
- Reset pulse asserted while in S_WAIT_DONE with 3 entries queued: expect draw=0, count=0, busy=0 immediately, and no doneStrobe after release.
- With DRAW_CMD_QUEUE_WATCHDOG_EN and TIMEOUT_CYCLES=50: drawer never returns ready. Expect timeout=1 at cycle 50, FSM back in S_IDLE, no doneStrobe.

Source files
------------

// File: rtl/draw_cmd_queue_pkg.sv
// Shared definitions for the sprite draw command queue.
//   LCD_WIDTH / LCD_HEIGHT : default display extents used for range checking
//   draw_cmd_t             : packed draw command {x[7:0], y[8:0], mif[7:0]} (25 bits)
//   issue_state_e          : issue FSM state encoding
//   cmd_in_range()         : true when a command origin lies on the display
package draw_cmd_queue_pkg;

    localparam int unsigned LCD_WIDTH  = 240;
    localparam int unsigned LCD_HEIGHT = 320;

    // Watchdog counter width; TIMEOUT_CYCLES must fit in this many bits.
    localparam int unsigned WD_WIDTH = 22;

    typedef struct packed {
        logic [7:0] x;
        logic [8:0] y;
        logic [7:0] mif;
    } draw_cmd_t;

    localparam int unsigned CMD_WIDTH = $bits(draw_cmd_t);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ASSERT    = 2'd1,
        S_WAIT_DONE = 2'd2
    } issue_state_e;

    function automatic logic cmd_in_range(input logic [7:0] x, input logic [8:0] y,
                                          input int unsigned width,
                                          input int unsigned height);
        return (32'(x) < width) && (32'(y) < height);
    endfunction

endpackage

// File: rtl/draw_cmd_queue_sync_fifo.sv
// Synchronous FIFO with registered pointers and a registered storage array.
// The head entry (rdata) is read straight from storage, so it is valid whenever
// empty=0. A push into a full FIFO is accepted only if a pop happens in the
// same cycle; a pop of an empty FIFO is ignored.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   push, wdata  : write request and data
//   pop          : remove head entry
//   rdata        : head entry
//   full, empty  : occupancy flags
//   count        : number of stored entries (0..DEPTH)
module draw_cmd_queue_sync_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/draw_cmd_queue.sv
// Draw command queue for the LT24 sprite drawer.
// Application logic pushes (x, y, sprite id) commands into a FIFO; the issue FSM
// hands them to the drawer one at a time over the draw/drawReady handshake and
// holds xOrigin/yOrigin/mifId stable for the whole draw.
// Optional feature: define DRAW_CMD_QUEUE_WATCHDOG_EN to enable a watchdog that
// abandons a draw after TIMEOUT_CYCLES busy cycles and sets the sticky timeout
// flag. Without it timeout is tied low and the FSM may wait indefinitely.
// Ports:
//   clock, reset                 : clock and asynchronous active-high reset
//   cmdValid, cmdX, cmdY, cmdMif : command push interface
//   cmdReady                     : FIFO not full
//   count                        : FIFO occupancy
//   overflow, rangeErr           : sticky drop flags (full / off-screen)
//   xOrigin, yOrigin, mifId, draw: registered drawer command outputs
//   drawReady                    : drawer ready
//   busy                         : a command is in flight
//   doneStrobe                   : one-cycle pulse when a draw completes
//   timeout                      : sticky watchdog flag
module draw_cmd_queue #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned LCD_WIDTH      = draw_cmd_queue_pkg::LCD_WIDTH,
    parameter int unsigned LCD_HEIGHT     = draw_cmd_queue_pkg::LCD_HEIGHT,
    parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmdValid,
    input  logic [7:0]             cmdX,
    input  logic [8:0]             cmdY,
    input  logic [7:0]             cmdMif,
    output logic                   cmdReady,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   rangeErr,
    output logic [7:0]             xOrigin,
    output logic [8:0]             yOrigin,
    output logic [7:0]             mifId,
    output logic                   draw,
    input  logic                   drawReady,
    output logic                   busy,
    output logic                   doneStrobe,
    output logic                   timeout
);

    import draw_cmd_queue_pkg::*;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << WD_WIDTH)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the watchdog counter");
    end

    issue_state_e state_q, state_d;
    draw_cmd_t    push_cmd;
    draw_cmd_t    head;
    draw_cmd_t    origin_q, origin_d;
    logic         draw_q, draw_d;
    logic         done_q, done_d;
    logic         overflow_q;
    logic         range_q;
    logic         in_rng;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign push_cmd = '{x: cmdX, y: cmdY, mif: cmdMif};
    assign in_rng   = cmd_in_range(cmdX, cmdY, LCD_WIDTH, LCD_HEIGHT);

    draw_cmd_queue_sync_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cmdValid && in_rng),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign cmdReady = !fifo_full;

    // Sticky drop flags. A full FIFO still accepts when the FSM pops this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            range_q    <= 1'b0;
        end else begin
            if (cmdValid && !in_rng) begin
                range_q <= 1'b1;
            end
            if (cmdValid && in_rng && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign overflow = overflow_q;
    assign rangeErr = range_q;

    // ------------------------------------------------------------------
    // Watchdog (optional)
    // ------------------------------------------------------------------
`ifdef DRAW_CMD_QUEUE_WATCHDOG_EN
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WD_WIDTH-1:0] wd_q, wd_d;
    logic                timeout_q, timeout_d;
    logic                wd_expired;

    // wd_q counts completed busy cycles, so expiry lands TIMEOUT_CYCLES
    // edges after S_ASSERT is entered.
    assign wd_expired = (state_q != S_IDLE) && (wd_q == WD_LAST);

    always_comb begin
        wd_d = '0;
        if (state_d == state_q && state_q != S_IDLE) begin
            wd_d = wd_q + WD_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        origin_d = origin_q;
        draw_d   = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;
`ifdef DRAW_CMD_QUEUE_WATCHDOG_EN
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && drawReady) begin
                    origin_d = head;
                    pop      = 1'b1;
                    state_d  = S_ASSERT;
                end
            end
            S_ASSERT: begin
                // drawReady falling is the drawer's acceptance of the command.
                if (!drawReady) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    draw_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (drawReady) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef DRAW_CMD_QUEUE_WATCHDOG_EN
        if (wd_expired) begin
            state_d   = S_IDLE;
            draw_d    = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            origin_q <= '0;
            draw_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            draw_q   <= draw_d;
            done_q   <= done_d;
        end
    end

    assign xOrigin    = origin_q.x;
    assign yOrigin    = origin_q.y;
    assign mifId      = origin_q.mif;
    assign draw       = draw_q;
    assign doneStrobe = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule
